// File: rtl/ecap5_dproc_pkg.sv
// ecap5_dproc_pkg: shared types and constants for the processor's Wishbone bus arbiter.
//   arb_state_t         - arbiter FSM states (idle, bus granted to fetch or load/store)
//   arb_master_t        - master identifiers used to remember the last grant
//   ARB_MAX_OUTSTANDING - default cap on accepted-but-unacknowledged requests per grant
package ecap5_dproc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_M0,
        GRANT_M1
    } arb_state_t;

    typedef enum logic {
        M0,
        M1
    } arb_master_t;

    localparam int ARB_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/wb_arbiter_counter.sv
// wb_arbiter_counter: saturating up/down counter of outstanding bus requests.
//   clk, rst_n - clock, asynchronous active-low reset (clears the count)
//   inc        - a request was accepted by the slave
//   dec        - an acknowledge was forwarded to the owning master
//   full       - count has reached MAX
//   empty      - count is zero
module wb_arbiter_counter #(
    parameter int MAX   = 4,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && !dec && !full)
            count <= count + 1'b1;
        else if (dec && !inc && !empty)
            count <= count - 1'b1;
    end

    assign full  = count == CNT_W'(MAX);
    assign empty = count == '0;

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin two-master / one-slave pipelined Wishbone arbiter.
//   clk_i, rst_ni     - clock, asynchronous active-low reset
//   m0_wb_*           - fetch master port (adr/dat/sel/we/stb/cyc in, dat/ack/stall out)
//   m1_wb_*           - load/store master port, same signals as m0
//   s_wb_*            - shared slave port (adr/dat/sel/we/stb/cyc out, dat/ack/stall in)
// The grant is held until the owner drops cyc and all its accepted requests are acked,
// so late responses always reach the master that issued them.
module wb_arbiter
    import ecap5_dproc_pkg::*;
#(
    parameter int MAX_OUTSTANDING = ARB_MAX_OUTSTANDING,
    parameter int CNT_W           = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] m0_wb_adr_i,
    input  logic [31:0] m0_wb_dat_i,
    input  logic [3:0]  m0_wb_sel_i,
    input  logic        m0_wb_we_i,
    input  logic        m0_wb_stb_i,
    input  logic        m0_wb_cyc_i,
    output logic [31:0] m0_wb_dat_o,
    output logic        m0_wb_ack_o,
    output logic        m0_wb_stall_o,
    input  logic [31:0] m1_wb_adr_i,
    input  logic [31:0] m1_wb_dat_i,
    input  logic [3:0]  m1_wb_sel_i,
    input  logic        m1_wb_we_i,
    input  logic        m1_wb_stb_i,
    input  logic        m1_wb_cyc_i,
    output logic [31:0] m1_wb_dat_o,
    output logic        m1_wb_ack_o,
    output logic        m1_wb_stall_o,
    output logic [31:0] s_wb_adr_o,
    output logic [31:0] s_wb_dat_o,
    output logic [3:0]  s_wb_sel_o,
    output logic        s_wb_we_o,
    output logic        s_wb_stb_o,
    output logic        s_wb_cyc_o,
    input  logic [31:0] s_wb_dat_i,
    input  logic        s_wb_ack_i,
    input  logic        s_wb_stall_i
);

    arb_state_t  state_q, state_d;
    arb_master_t last_q;
    logic        full, empty, granted, sel, accept, ack_fwd, own_stall;

    assign granted = state_q != IDLE;
    assign sel     = state_q == GRANT_M1;

    assign s_wb_adr_o = granted ? (sel ? m1_wb_adr_i : m0_wb_adr_i) : '0;
    assign s_wb_dat_o = granted ? (sel ? m1_wb_dat_i : m0_wb_dat_i) : '0;
    assign s_wb_sel_o = granted ? (sel ? m1_wb_sel_i : m0_wb_sel_i) : '0;
    assign s_wb_we_o  = granted && (sel ? m1_wb_we_i : m0_wb_we_i);
    assign s_wb_stb_o = granted && (sel ? m1_wb_stb_i : m0_wb_stb_i) && !full;
    assign s_wb_cyc_o = granted && ((sel ? m1_wb_cyc_i : m0_wb_cyc_i) || !empty);

    // Acks with nothing outstanding are stray responses (e.g. from before a reset) and are dropped.
    assign accept    = s_wb_stb_o && !s_wb_stall_i;
    assign ack_fwd   = granted && s_wb_ack_i && !empty;
    assign own_stall = s_wb_stall_i || full;

    assign m0_wb_dat_o   = s_wb_dat_i;
    assign m1_wb_dat_o   = s_wb_dat_i;
    assign m0_wb_ack_o   = state_q == GRANT_M0 && ack_fwd;
    assign m1_wb_ack_o   = state_q == GRANT_M1 && ack_fwd;
    assign m0_wb_stall_o = state_q == GRANT_M0 ? own_stall : 1'b1;
    assign m1_wb_stall_o = state_q == GRANT_M1 ? own_stall : 1'b1;

    wb_arbiter_counter #(
        .MAX   (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .inc   (accept),
        .dec   (ack_fwd),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:
                state_d = (m0_wb_cyc_i && m1_wb_cyc_i) ? (last_q == M1 ? GRANT_M0 : GRANT_M1) :
                          m0_wb_cyc_i ? GRANT_M0 :
                          m1_wb_cyc_i ? GRANT_M1 : IDLE;
            // Hand over directly to a waiting master to avoid an idle bubble.
            GRANT_M0:
                if (!m0_wb_cyc_i && empty) state_d = m1_wb_cyc_i ? GRANT_M1 : IDLE;
            GRANT_M1:
                if (!m1_wb_cyc_i && empty) state_d = m0_wb_cyc_i ? GRANT_M0 : IDLE;
            default:
                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= M1;
        end else begin
            state_q <= state_d;
            if (state_d == GRANT_M0)
                last_q <= M0;
            else if (state_d == GRANT_M1)
                last_q <= M1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized self-checking bench for wb_arbiter against a behavioural model.
module tb_wb_arbiter;

    localparam int MAX = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] m0_wb_adr_i, m0_wb_dat_i, m1_wb_adr_i, m1_wb_dat_i;
    logic [3:0]  m0_wb_sel_i, m1_wb_sel_i;
    logic        m0_wb_we_i, m0_wb_stb_i, m0_wb_cyc_i;
    logic        m1_wb_we_i, m1_wb_stb_i, m1_wb_cyc_i;
    logic [31:0] m0_wb_dat_o, m1_wb_dat_o;
    logic        m0_wb_ack_o, m0_wb_stall_o, m1_wb_ack_o, m1_wb_stall_o;
    logic [31:0] s_wb_adr_o, s_wb_dat_o, s_wb_dat_i;
    logic [3:0]  s_wb_sel_o;
    logic        s_wb_we_o, s_wb_stb_o, s_wb_cyc_o, s_wb_ack_i, s_wb_stall_i;

    int total = 0;
    int bad = 0;

    // Model: owner 0 = nobody, 1 = fetch, 2 = load/store; prev = last master granted.
    int owner = 0;
    int prev = 2;
    int pend = 0;

    wb_arbiter dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .m0_wb_adr_i   (m0_wb_adr_i),
        .m0_wb_dat_i   (m0_wb_dat_i),
        .m0_wb_sel_i   (m0_wb_sel_i),
        .m0_wb_we_i    (m0_wb_we_i),
        .m0_wb_stb_i   (m0_wb_stb_i),
        .m0_wb_cyc_i   (m0_wb_cyc_i),
        .m0_wb_dat_o   (m0_wb_dat_o),
        .m0_wb_ack_o   (m0_wb_ack_o),
        .m0_wb_stall_o (m0_wb_stall_o),
        .m1_wb_adr_i   (m1_wb_adr_i),
        .m1_wb_dat_i   (m1_wb_dat_i),
        .m1_wb_sel_i   (m1_wb_sel_i),
        .m1_wb_we_i    (m1_wb_we_i),
        .m1_wb_stb_i   (m1_wb_stb_i),
        .m1_wb_cyc_i   (m1_wb_cyc_i),
        .m1_wb_dat_o   (m1_wb_dat_o),
        .m1_wb_ack_o   (m1_wb_ack_o),
        .m1_wb_stall_o (m1_wb_stall_o),
        .s_wb_adr_o    (s_wb_adr_o),
        .s_wb_dat_o    (s_wb_dat_o),
        .s_wb_sel_o    (s_wb_sel_o),
        .s_wb_we_o     (s_wb_we_o),
        .s_wb_stb_o    (s_wb_stb_o),
        .s_wb_cyc_o    (s_wb_cyc_o),
        .s_wb_dat_i    (s_wb_dat_i),
        .s_wb_ack_i    (s_wb_ack_i),
        .s_wb_stall_i  (s_wb_stall_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit        g1, g2, full, own_stb, own_cyc;
        logic [31:0] adr, dat;
        logic [3:0]  bsel;
        logic        we;
        g1 = owner == 1;
        g2 = owner == 2;
        full = pend == MAX;
        adr  = g1 ? m0_wb_adr_i : g2 ? m1_wb_adr_i : 32'h0;
        dat  = g1 ? m0_wb_dat_i : g2 ? m1_wb_dat_i : 32'h0;
        bsel = g1 ? m0_wb_sel_i : g2 ? m1_wb_sel_i : 4'h0;
        we   = g1 ? m0_wb_we_i : g2 ? m1_wb_we_i : 1'b0;
        own_stb = g1 ? m0_wb_stb_i : g2 ? m1_wb_stb_i : 1'b0;
        own_cyc = g1 ? m0_wb_cyc_i : g2 ? m1_wb_cyc_i : 1'b0;
        check("s_adr", s_wb_adr_o, adr);
        check("s_dat", s_wb_dat_o, dat);
        check("s_sel", 32'(s_wb_sel_o), 32'(bsel));
        check("s_we", 32'(s_wb_we_o), 32'(we));
        check("s_stb", 32'(s_wb_stb_o), 32'(own_stb && !full));
        check("s_cyc", 32'(s_wb_cyc_o), 32'((owner != 0) && (own_cyc || pend != 0)));
        check("m0_stall", 32'(m0_wb_stall_o), 32'(g1 ? (s_wb_stall_i || full) : 1'b1));
        check("m1_stall", 32'(m1_wb_stall_o), 32'(g2 ? (s_wb_stall_i || full) : 1'b1));
        check("m0_ack", 32'(m0_wb_ack_o), 32'(g1 && s_wb_ack_i && pend != 0));
        check("m1_ack", 32'(m1_wb_ack_o), 32'(g2 && s_wb_ack_i && pend != 0));
        check("m0_dat", m0_wb_dat_o, s_wb_dat_i);
        check("m1_dat", m1_wb_dat_o, s_wb_dat_i);
    endtask

    // Advance the model by one clock using the inputs held over the edge.
    task automatic model_step();
        bit own_stb, own_cyc, other_cyc;
        int old_pend;
        own_stb   = owner == 1 ? m0_wb_stb_i : owner == 2 ? m1_wb_stb_i : 1'b0;
        own_cyc   = owner == 1 ? m0_wb_cyc_i : m1_wb_cyc_i;
        other_cyc = owner == 1 ? m1_wb_cyc_i : m0_wb_cyc_i;
        old_pend = pend;
        if (owner != 0 && own_stb && pend < MAX && !s_wb_stall_i) pend++;
        if (owner != 0 && s_wb_ack_i && old_pend > 0) pend--;
        if (owner == 0) begin
            if (m0_wb_cyc_i && m1_wb_cyc_i) owner = (prev == 2) ? 1 : 2;
            else if (m0_wb_cyc_i) owner = 1;
            else if (m1_wb_cyc_i) owner = 2;
        end else if (!own_cyc && old_pend == 0) begin
            owner = other_cyc ? 3 - owner : 0;
        end
        if (owner != 0) prev = owner;
    endtask

    task automatic run_cycle(input int ack_div, input int stall_div, input int drop_div, input bit allow_rst);
        @(negedge clk_i);
        rst_ni = !(allow_rst && $urandom_range(63) == 0);
        m0_wb_cyc_i = m0_wb_cyc_i ? ($urandom_range(drop_div - 1) != 0) : ($urandom_range(3) == 0);
        m1_wb_cyc_i = m1_wb_cyc_i ? ($urandom_range(drop_div - 1) != 0) : ($urandom_range(3) == 0);
        m0_wb_stb_i = m0_wb_cyc_i && $urandom_range(3) != 0;
        m1_wb_stb_i = m1_wb_cyc_i && $urandom_range(3) != 0;
        m0_wb_adr_i = $urandom;
        m0_wb_dat_i = $urandom;
        m0_wb_sel_i = 4'($urandom);
        m0_wb_we_i  = 1'($urandom);
        m1_wb_adr_i = $urandom;
        m1_wb_dat_i = $urandom;
        m1_wb_sel_i = 4'($urandom);
        m1_wb_we_i  = 1'($urandom);
        s_wb_dat_i   = $urandom;
        s_wb_ack_i   = $urandom_range(ack_div - 1) == 0;
        s_wb_stall_i = $urandom_range(stall_div - 1) == 0;
        if (!rst_ni) begin
            owner = 0;
            pend = 0;
            prev = 2;
        end
        #1;
        check_outputs();
        @(posedge clk_i);
        if (rst_ni) model_step();
    endtask

    initial begin
        {m0_wb_adr_i, m0_wb_dat_i, m0_wb_sel_i, m0_wb_we_i, m0_wb_stb_i, m0_wb_cyc_i} = '0;
        {m1_wb_adr_i, m1_wb_dat_i, m1_wb_sel_i, m1_wb_we_i, m1_wb_stb_i, m1_wb_cyc_i} = '0;
        {s_wb_dat_i, s_wb_ack_i, s_wb_stall_i} = '0;
        s_wb_dat_i = 32'h0000_0013;
        s_wb_ack_i = 1'b1;
        m0_wb_cyc_i = 1'b1;
        m1_wb_cyc_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        check_outputs();
        m0_wb_cyc_i = 1'b0;
        m1_wb_cyc_i = 1'b0;
        s_wb_ack_i = 1'b0;
        for (int i = 0; i < 1500; i++) run_cycle(2, 4, 8, 1'b0);
        for (int i = 0; i < 1500; i++) run_cycle(10, 8, 32, 1'b0);
        for (int i = 0; i < 1500; i++) run_cycle(4, 3, 12, 1'b1);
        for (int i = 0; i < 1500; i++) run_cycle(6, 16, 24, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
